// File: rtl/stack_pkg.sv
// Shared encodings for the stack sequencer: op codes, FSM states, word-slot
// codes and small decode helpers used by the sequencer.
package stack_pkg;

    localparam logic [1:0] OP_CALL = 2'b00;
    localparam logic [1:0] OP_RET  = 2'b01;
    localparam logic [1:0] OP_INT  = 2'b10;
    localparam logic [1:0] OP_RTI  = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WR   = 3'd1;
    localparam logic [2:0] ST_RD   = 3'd2;
    localparam logic [2:0] ST_RDW  = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    localparam logic [1:0] SEG_PC_H  = 2'b00;
    localparam logic [1:0] SEG_PC_L  = 2'b01;
    localparam logic [1:0] SEG_FLAGS = 2'b10;

    // CALL and INT push onto the stack; RET and RTI pop.
    function automatic logic is_push(input logic [1:0] op);
        return !(op == OP_RET || op == OP_RTI);
    endfunction

    // Interrupt entry/exit move the flags word as well as the PC.
    function automatic logic [1:0] word_count(input logic [1:0] op);
        return (op == OP_INT || op == OP_RTI) ? 2'd3 : 2'd2;
    endfunction

    // Which word a transfer carries, given the op and the words still to go.
    // Pushes store PC high first; pops see the reverse order.
    function automatic logic [1:0] seg_of(input logic [1:0] op, input logic [1:0] cnt);
        logic [1:0] seg;
        if (is_push(op)) begin
            case (cnt)
                2'd1:    seg = (op == OP_INT) ? SEG_FLAGS : SEG_PC_L;
                2'd2:    seg = (op == OP_INT) ? SEG_PC_L  : SEG_PC_H;
                default: seg = SEG_PC_H;
            endcase
        end else begin
            case (cnt)
                2'd3:    seg = SEG_FLAGS;
                2'd2:    seg = SEG_PC_L;
                default: seg = SEG_PC_H;
            endcase
        end
        return seg;
    endfunction

endpackage

// File: rtl/sp_unit.sv
// Stack pointer register: downward-growing stack, modulo wrap, sticky
// overflow/underflow flag cleared only by reset.
module sp_unit #(
    parameter int          ADDR_W   = 12,
    parameter int unsigned SP_RESET = 2**ADDR_W - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec,
    input  logic              inc,
    output logic [ADDR_W-1:0] sp,
    output logic              stk_err
);

    localparam logic [ADDR_W-1:0] SP_INIT = ADDR_W'(SP_RESET);
    localparam logic [ADDR_W-1:0] SP_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] SP_MAX  = '1;

    // Step SP on granted transfers; flag any wrap past either end.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp      <= SP_INIT;
            stk_err <= 1'b0;
        end else if (dec) begin
            sp <= sp - SP_ONE;
            if (sp == '0) stk_err <= 1'b1;
        end else if (inc) begin
            sp <= sp + SP_ONE;
            if (sp == SP_MAX) stk_err <= 1'b1;
        end
    end

endmodule

// File: rtl/stack_sequencer.sv
// Sequences CALL/RET/INT/RTI as one 16-bit stack-port word per granted cycle,
// stalls fetch while busy and issues the PC (and flags) redirect at the end.
module stack_sequencer #(
    parameter int          ADDR_W     = 12,
    parameter int unsigned SP_RESET   = 2**ADDR_W - 1,
    parameter logic [31:0] INT_VECTOR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [1:0]        op_code,
    output logic              op_ready,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       target_in,
    input  logic [3:0]        flags_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic [15:0]       mem_rdata,
    output logic              stall_fetch,
    output logic              pc_load,
    output logic [31:0]       pc_out,
    output logic              flags_load,
    output logic [3:0]        flags_out,
    output logic [ADDR_W-1:0] sp,
    output logic              stk_err
);
    import stack_pkg::*;

    localparam logic [ADDR_W-1:0] SP_ONE = ADDR_W'(1);

    logic [2:0]  state;
    logic [1:0]  cnt;
    logic [1:0]  op_q;
    logic [31:0] ret_pc_q;
    logic [31:0] target_q;
    logic [3:0]  flags_q;
    logic [31:0] pop_pc_q;
    logic [3:0]  pop_flags_q;
    logic [1:0]  seg;

    assign seg = seg_of(op_q, cnt);

    sp_unit #(
        .ADDR_W   (ADDR_W),
        .SP_RESET (SP_RESET)
    ) u_sp (
        .clk     (clk),
        .rst     (rst),
        .dec     (state == ST_WR && mem_gnt),
        .inc     (state == ST_RD && mem_gnt),
        .sp      (sp),
        .stk_err (stk_err)
    );

    // FSM: state and remaining-word count; only control is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        cnt   <= word_count(op_code);
                        state <= is_push(op_code) ? ST_WR : ST_RD;
                    end
                end
                ST_WR: begin
                    if (mem_gnt) begin
                        cnt <= cnt - 2'd1;
                        if (cnt == 2'd1) state <= ST_FIN;
                    end
                end
                ST_RD: begin
                    if (mem_gnt) state <= ST_RDW;
                end
                ST_RDW: begin
                    cnt   <= cnt - 2'd1;
                    state <= (cnt == 2'd1) ? ST_FIN : ST_RD;
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operand latch at accept and popped-word capture; outputs are gated by
    // state, so these registers need no reset.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && op_valid) begin
            op_q     <= op_code;
            ret_pc_q <= pc_in;
            target_q <= target_in;
            flags_q  <= flags_in;
        end
        if (state == ST_RDW) begin
            case (seg)
                SEG_PC_H:  pop_pc_q[31:16] <= mem_rdata;
                SEG_PC_L:  pop_pc_q[15:0]  <= mem_rdata;
                default:   pop_flags_q     <= mem_rdata[3:0];
            endcase
        end
    end

    // Output decode from registered state only (no mem_gnt to mem_addr path).
    always_comb begin
        op_ready    = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = 16'h0000;
        stall_fetch = 1'b0;
        pc_load     = 1'b0;
        pc_out      = 32'h0000_0000;
        flags_load  = 1'b0;
        flags_out   = 4'h0;
        case (state)
            ST_IDLE: op_ready = 1'b1;
            ST_WR: begin
                stall_fetch = 1'b1;
                mem_req     = 1'b1;
                mem_we      = 1'b1;
                mem_addr    = sp;
                case (seg)
                    SEG_PC_H: mem_wdata = ret_pc_q[31:16];
                    SEG_PC_L: mem_wdata = ret_pc_q[15:0];
                    default:  mem_wdata = {12'h000, flags_q};
                endcase
            end
            ST_RD: begin
                stall_fetch = 1'b1;
                mem_req     = 1'b1;
                mem_addr    = sp + SP_ONE;
            end
            ST_RDW: stall_fetch = 1'b1;
            ST_FIN: begin
                stall_fetch = 1'b1;
                pc_load     = 1'b1;
                case (op_q)
                    OP_CALL: pc_out = target_q;
                    OP_INT:  pc_out = INT_VECTOR;
                    default: pc_out = pop_pc_q;
                endcase
                if (op_q == OP_RTI) begin
                    flags_load = 1'b1;
                    flags_out  = pop_flags_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: expected memory accesses and PC/flags
// redirects are queued when an op is issued and checked as the DUT emits them.
module tb_stack_sequencer;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              op_valid;
    logic [1:0]        op_code;
    logic              op_ready;
    logic [31:0]       pc_in;
    logic [31:0]       target_in;
    logic [3:0]        flags_in;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_gnt;
    logic [15:0]       mem_rdata;
    logic              stall_fetch;
    logic              pc_load;
    logic [31:0]       pc_out;
    logic              flags_load;
    logic [3:0]        flags_out;
    logic [ADDR_W-1:0] sp;
    logic              stk_err;

    stack_sequencer #(
        .ADDR_W     (ADDR_W),
        .SP_RESET   (4095),
        .INT_VECTOR (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_code     (op_code),
        .op_ready    (op_ready),
        .pc_in       (pc_in),
        .target_in   (target_in),
        .flags_in    (flags_in),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .mem_rdata   (mem_rdata),
        .stall_fetch (stall_fetch),
        .pc_load     (pc_load),
        .pc_out      (pc_out),
        .flags_load  (flags_load),
        .flags_out   (flags_out),
        .sp          (sp),
        .stk_err     (stk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        we;
        logic [11:0] addr;
        logic [15:0] data;
    } acc_t;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic        fl_ld;
        logic [3:0]  fl;
    } pce_t;

    acc_t        acc_q[$];
    pce_t        pc_q[$];
    logic [15:0] mem [0:4095];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          rd_pend = 1'b0;
    logic [11:0] rd_addr;
    bit          prev_hold = 1'b0;
    logic [11:0] prev_addr;
    logic [15:0] prev_wdata;
    logic [11:0] prev_sp;
    int          t0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic exp_acc(input int c, input logic we, input logic [11:0] a, input logic [15:0] d);
        acc_q.push_back('{c, we, a, d});
    endtask

    task automatic exp_pc(input int c, input logic [31:0] p, input logic fld, input logic [3:0] f);
        pc_q.push_back('{c, p, fld, f});
    endtask

    // Observe the current cycle (sampled at the falling edge).
    task automatic monitor();
        acc_t e;
        pce_t p;
        if (prev_hold && mem_req) begin
            chk("hold_addr", mem_addr, prev_addr);
            chk("hold_wdata", mem_wdata, prev_wdata);
            chk("hold_sp", sp, prev_sp);
        end
        prev_hold  = (mem_req === 1'b1) && (mem_gnt === 1'b0);
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        prev_sp    = sp;
        if (mem_req && mem_gnt) begin
            chk("acc_pending", acc_q.size() > 0, 1);
            if (acc_q.size() > 0) begin
                e = acc_q.pop_front();
                chk("acc_cycle", cyc, e.cyc);
                chk("acc_we", mem_we, e.we);
                chk("acc_addr", mem_addr, e.addr);
                if (e.we) chk("acc_wdata", mem_wdata, e.data);
            end
            if (mem_we) mem[mem_addr] = mem_wdata;
            else begin
                rd_pend = 1'b1;
                rd_addr = mem_addr;
            end
        end
        if (pc_load) begin
            chk("pc_pending", pc_q.size() > 0, 1);
            if (pc_q.size() > 0) begin
                p = pc_q.pop_front();
                chk("pc_cycle", cyc, p.cyc);
                chk("pc_out", pc_out, p.pc);
                chk("flags_load", flags_load, p.fl_ld);
                if (p.fl_ld) chk("flags_out", flags_out, p.fl);
            end
        end else if (flags_load) begin
            chk("flags_stray", flags_load, 0);
        end
    endtask

    task automatic step();
        monitor();
        @(posedge clk);
        @(negedge clk);
        if (rd_pend) begin
            mem_rdata = mem[rd_addr];
            rd_pend   = 1'b0;
        end else begin
            mem_rdata = 16'h0000;
        end
        cyc++;
    endtask

    // Issue one op (accept at the current cycle) and run it to completion,
    // withholding grant for gap_len cycles starting gap_at cycles after accept.
    task automatic do_op(input logic [1:0] op, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [3:0] fl, input int gap_at, input int gap_len, input string tag);
        int ta;
        ta        = cyc;
        op_valid  = 1'b1;
        op_code   = op;
        pc_in     = pc;
        target_in = tgt;
        flags_in  = fl;
        mem_gnt   = 1'b1;
        chk({tag, "_ready"}, op_ready, 1);
        step();
        op_valid  = 1'b0;
        pc_in     = 32'hFFFF_FFFF;
        target_in = 32'hFFFF_FFFF;
        flags_in  = 4'h5;
        chk({tag, "_stall"}, stall_fetch, 1);
        chk({tag, "_busy"}, op_ready, 0);
        for (int k = 0; k < 30 && !op_ready; k++) begin
            mem_gnt = !((cyc - ta) >= gap_at && (cyc - ta) < gap_at + gap_len);
            step();
        end
        mem_gnt = 1'b1;
        chk({tag, "_done"}, op_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'(i) ^ 16'h5A5A;
        rst = 1'b1; op_valid = 1'b0; op_code = 2'b00; pc_in = '0; target_in = '0;
        flags_in = '0; mem_gnt = 1'b1; mem_rdata = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_ready", op_ready, 1);
        chk("rst_stall", stall_fetch, 0);
        chk("rst_sp", sp, 4095);
        chk("rst_err", stk_err, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_pcload", pc_load, 0);
        chk("rst_pcout", pc_out, 0);
        chk("rst_flout", flags_out, 0);

        // CALL
        t0 = cyc;
        exp_acc(t0 + 1, 1'b1, 12'd4095, 16'h0001);
        exp_acc(t0 + 2, 1'b1, 12'd4094, 16'h2345);
        exp_pc(t0 + 3, 32'h0000_0100, 1'b0, 4'h0);
        do_op(2'b00, 32'h0001_2345, 32'h0000_0100, 4'h0, 99, 0, "call");
        chk("call_sp", sp, 4093);

        // RET right after the CALL
        t0 = cyc;
        exp_acc(t0 + 1, 1'b0, 12'd4094, 16'h0);
        exp_acc(t0 + 3, 1'b0, 12'd4095, 16'h0);
        exp_pc(t0 + 5, 32'h0001_2345, 1'b0, 4'h0);
        do_op(2'b01, 32'h0, 32'h0, 4'h0, 99, 0, "ret");
        chk("ret_sp", sp, 4095);
        chk("ret_err", stk_err, 0);

        // INT then RTI
        t0 = cyc;
        exp_acc(t0 + 1, 1'b1, 12'd4095, 16'h1234);
        exp_acc(t0 + 2, 1'b1, 12'd4094, 16'h5678);
        exp_acc(t0 + 3, 1'b1, 12'd4093, 16'h000A);
        exp_pc(t0 + 4, 32'h0000_0000, 1'b0, 4'h0);
        do_op(2'b10, 32'h1234_5678, 32'h0000_0777, 4'b1010, 99, 0, "int");
        chk("int_sp", sp, 4092);

        t0 = cyc;
        exp_acc(t0 + 1, 1'b0, 12'd4093, 16'h0);
        exp_acc(t0 + 3, 1'b0, 12'd4094, 16'h0);
        exp_acc(t0 + 5, 1'b0, 12'd4095, 16'h0);
        exp_pc(t0 + 7, 32'h1234_5678, 1'b1, 4'hA);
        do_op(2'b11, 32'h0, 32'h0, 4'h0, 99, 0, "rti");
        chk("rti_sp", sp, 4095);

        // CALL with grant withheld for two cycles on the second write
        t0 = cyc;
        exp_acc(t0 + 1, 1'b1, 12'd4095, 16'hDEAD);
        exp_acc(t0 + 4, 1'b1, 12'd4094, 16'hBEEF);
        exp_pc(t0 + 5, 32'h0000_0200, 1'b0, 4'h0);
        do_op(2'b00, 32'hDEAD_BEEF, 32'h0000_0200, 4'h0, 2, 2, "gap");
        chk("gap_sp", sp, 4093);

        // Underflow: RET from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("uf_sp0", sp, 4095);
        t0 = cyc;
        exp_acc(t0 + 1, 1'b0, 12'd0, 16'h0);
        exp_acc(t0 + 3, 1'b0, 12'd1, 16'h0);
        exp_pc(t0 + 5, 32'h5A5B_5A5A, 1'b0, 4'h0);
        do_op(2'b01, 32'h0, 32'h0, 4'h0, 99, 0, "uf");
        chk("uf_sp", sp, 1);
        chk("uf_err", stk_err, 1);
        for (int k = 0; k < 3; k++) step();
        chk("uf_err_sticky", stk_err, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("uf_err_clr", stk_err, 0);

        // Reset during the second INT write
        t0 = cyc;
        exp_acc(t0 + 1, 1'b1, 12'd4095, 16'hCAFE);
        exp_acc(t0 + 2, 1'b1, 12'd4094, 16'hF00D);
        op_valid = 1'b1; op_code = 2'b10; pc_in = 32'hCAFE_F00D; flags_in = 4'h3;
        step();
        op_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_ready", op_ready, 1);
        chk("mid_stall", stall_fetch, 0);
        chk("mid_sp", sp, 4095);
        chk("mid_req", mem_req, 0);
        chk("mid_pcload", pc_load, 0);
        for (int k = 0; k < 5; k++) step();

        chk("acc_q_empty", acc_q.size(), 0);
        chk("pc_q_empty", pc_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
